lfsr13_seq: RTL
===============

# lfsr13_seq

Sequenced 13-bit maximal-length Fibonacci LFSR that feeds the downstream ones/zeros tally stage. Supplies the serial bit `msb_out`, a `max_tick` pulse on each full-period wrap, and a start/stop/done control interface. It sits directly upstream of the bit counter, which clears its tallies on `max_tick`.

## Interface
- `SEED_RST`, 13'h0001, seed register value after reset; must be nonzero.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a run; honoured in IDLE only.
- `stop`  in  1  abort the run; honoured in RUN only.
- `continuous`  in  1  sampled on entry to LOAD; 1 = wrap forever, 0 = one period then DONE.
- `seed_load`  in  1  write `seed` into the seed register; honoured in IDLE only.
- `seed`  in  13  new seed value.
- `lfsr_out`  out  13  current LFSR state.
- `msb_out`  out  1  `lfsr_out[12]`.
- `msb_valid`  out  1  high while in RUN.
- `max_tick`  out  1  one-cycle pulse when the state returns to the seed.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse when a single-period run completes.
- `seed_err`  out  1  one-cycle pulse when a zero seed is rejected.
- `period_err`  out  1  sticky period-check failure; see Configuration.

## Operation
- Polynomial x^13+x^4+x^3+x+1.
  - Step: `lfsr_q <= {lfsr_q[11:0], fb}`.
  - `fb = lfsr_q[12]^lfsr_q[3]^lfsr_q[2]^lfsr_q[0]`.
  - Period is 8191. The all-zero state is never reachable.
- Reset values:
  - `seed_q = SEED_RST`, `lfsr_q = SEED_RST`, state IDLE, `run_cont = 0`.
  - All pulse outputs, `busy`, `msb_valid` and `period_err` are 0.
- States:
  - **IDLE**: `lfsr_q` holds. `seed_load` with nonzero `seed` writes `seed_q`. `seed_load` with `seed == 0` leaves `seed_q` unchanged and pulses `seed_err`. `start` goes to LOAD.
  - **LOAD** (one cycle): `lfsr_q <= seed_q`, `run_cont <= continuous`, step counter cleared, `period_err` cleared. Then go to RUN.
  - **RUN**: `lfsr_q` steps every cycle.
    - Wrap is defined as `lfsr_next == seed_q`. On wrap the next cycle has `max_tick = 1` and `lfsr_out == seed_q`.
    - On wrap with `run_cont = 1`: stay in RUN.
    - On wrap with `run_cont = 0`: go to DONE.
  - **DONE** (one cycle): `done = 1`, `lfsr_q` holds the seed. Then go to IDLE.
- `stop` in RUN: go to IDLE next cycle. `lfsr_q` freezes at its current value. No `done`. A `max_tick` already scheduled for that same edge still fires.
- Simultaneous events:
  - `seed_load` and `start` in the same IDLE cycle: the seed is written first, and LOAD uses the new seed. If the new seed is rejected, LOAD uses the old seed.
  - `start` outside IDLE and `seed_load` outside IDLE are ignored.
  - `stop` and a wrap in the same RUN cycle: `stop` wins. The next state is IDLE and `max_tick` still pulses.
- All outputs are registered. `rst_n` low mid-run returns every register to its reset value immediately.

## Timing
- `start` at edge N: LOAD in cycle N+1, RUN from N+2 with `lfsr_out == seed_q`. The first step is visible at N+3.
- `max_tick` first asserts 8191 cycles after RUN entry, then every 8191 cycles in continuous mode.
- `done` asserts in the cycle after the `max_tick` cycle in single mode. `busy` is low from the `done` cycle onward.
- `seed_err` asserts in the cycle after the offending `seed_load`.

## Configuration
- Macro `LFSR13_PERIOD_CHECK_EN`.
- Defined:
  - A 13-bit step counter increments on each RUN step.
  - At each wrap the counter must equal 8190 (8191 steps); it is then cleared.
  - A mismatch sets `period_err`, which stays set until the next LOAD or reset.
- Undefined: no counter is built, and `period_err` is tied to 0.

## Test plan
- Reset, then load seed 13'h0001 and `start` with `continuous = 0`: `lfsr_out` runs 0001 → 0003 → 0007 → 000E. `max_tick` fires after 8191 RUN cycles, `done` fires the next cycle, and `busy` then drops.
- Continuous run from seed 13'h1ABC: `max_tick` at exactly 8191-cycle spacing three times, `lfsr_out == 13'h1ABC` at each tick, and `period_err = 0` with the check enabled.
- `seed_load` with `seed = 0`: `seed_err` pulses once and `seed_q` is unchanged. A following `start` runs from the old seed.
- `stop` 100 cycles into RUN: IDLE next cycle, `lfsr_out` frozen, no `done`, no `max_tick`. A later `start` reloads the seed.
- `rst_n` pulsed low mid-run: all outputs immediately return to their reset values and `lfsr_out == SEED_RST`. `start` and `seed_load` while busy have no effect.
- With the check enabled, force the step counter off by one: `period_err` sets at the next wrap and clears on the next LOAD.

Source files
------------

// File: rtl/lfsr13_seq_if.sv
// Control/status bundle for lfsr13_seq: the master drives requests and the seed,
// the slave (the LFSR sequencer) returns state, pulses and status.
interface lfsr13_seq_if;
   logic        start;
   logic        stop;
   logic        continuous;
   logic        seed_load;
   logic [12:0] seed;
   logic [12:0] lfsr_out;
   logic        msb_out;
   logic        msb_valid;
   logic        max_tick;
   logic        busy;
   logic        done;
   logic        seed_err;
   logic        period_err;

   modport master (
      output start, stop, continuous, seed_load, seed,
      input  lfsr_out, msb_out, msb_valid, max_tick, busy, done, seed_err, period_err
   );

   modport slave (
      input  start, stop, continuous, seed_load, seed,
      output lfsr_out, msb_out, msb_valid, max_tick, busy, done, seed_err, period_err
   );
endinterface

// File: rtl/lfsr13_seq.sv
// Sequenced 13-bit Fibonacci LFSR (x^13+x^4+x^3+x+1) with start/stop/done control.
// Optional period self-check is built when LFSR13_PERIOD_CHECK_EN is defined.
module lfsr13_seq #(
   parameter logic [12:0] SEED_RST = 13'h0001
) (
   input  logic        clk,
   input  logic        rst_n,
   lfsr13_seq_if.slave io_bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [12:0] r_seed;
   logic [12:0] r_lfsr;
   logic [12:0] w_lfsr_next;
   logic [12:0] w_lfsr_step;
   logic        w_fb;
   logic        w_wrap;
   logic        w_seed_wr;
   logic        w_seed_rej;
   logic        r_run_cont;
   logic        r_max_tick;
   logic        r_done;
   logic        r_seed_err;
   logic        r_busy;
   logic        r_msb_valid;

   assign w_fb        = r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0];
   assign w_lfsr_step = {r_lfsr[11:0], w_fb};
   // Wrap is the step that brings the state back onto the seed.
   assign w_wrap      = (r_state == StRun) && (w_lfsr_step == r_seed);
   assign w_seed_wr   = (r_state == StIdle) && io_bus.seed_load && (io_bus.seed != 13'd0);
   assign w_seed_rej  = (r_state == StIdle) && io_bus.seed_load && (io_bus.seed == 13'd0);

   always_comb begin
      w_state_next = r_state;
      w_lfsr_next  = r_lfsr;
      case (r_state)
         StIdle: begin
            if (io_bus.start) w_state_next = StLoad;
         end
         StLoad: begin
            w_lfsr_next  = r_seed;
            w_state_next = StRun;
         end
         StRun: begin
            if (io_bus.stop) begin
               w_state_next = StIdle;
            end else begin
               w_lfsr_next = w_lfsr_step;
               if (w_wrap && !r_run_cont) w_state_next = StDone;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_seed      <= SEED_RST;
         r_lfsr      <= SEED_RST;
         r_run_cont  <= 1'b0;
         r_max_tick  <= 1'b0;
         r_done      <= 1'b0;
         r_seed_err  <= 1'b0;
         r_busy      <= 1'b0;
         r_msb_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_lfsr      <= w_lfsr_next;
         if (w_seed_wr) r_seed <= io_bus.seed;
         if (r_state == StLoad) r_run_cont <= io_bus.continuous;
         // A wrap coinciding with stop still reports the tick.
         r_max_tick  <= w_wrap;
         // done lands one cycle after the tick, i.e. on the way out of DONE.
         r_done      <= (r_state == StDone);
         r_seed_err  <= w_seed_rej;
         r_busy      <= (w_state_next == StLoad) || (w_state_next == StRun);
         r_msb_valid <= (w_state_next == StRun);
      end
   end

   assign io_bus.lfsr_out  = r_lfsr;
   assign io_bus.msb_out   = r_lfsr[12];
   assign io_bus.msb_valid = r_msb_valid;
   assign io_bus.max_tick  = r_max_tick;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;
   assign io_bus.seed_err  = r_seed_err;

`ifdef LFSR13_PERIOD_CHECK_EN
   logic [12:0] r_step_cnt;
   logic        r_period_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_cnt   <= 13'd0;
         r_period_err <= 1'b0;
      end else if (r_state == StLoad) begin
         r_step_cnt   <= 13'd0;
         r_period_err <= 1'b0;
      end else if (w_wrap) begin
         // 8191 steps per period: 8190 counted before the wrapping step.
         r_step_cnt <= 13'd0;
         if (r_step_cnt != 13'd8190) r_period_err <= 1'b1;
      end else if ((r_state == StRun) && !io_bus.stop) begin
         r_step_cnt <= r_step_cnt + 13'd1;
      end
   end

   assign io_bus.period_err = r_period_err;
`else
   assign io_bus.period_err = 1'b0;
`endif

endmodule
